// File: rtl/mem_stage.sv
// MEM-stage access unit: drives the data-memory req/ready handshake, stalls upstream while an access is outstanding.
// Optional macro MEM_TIMEOUT_EN adds a WAIT-cycle watchdog that force-commits and raises a sticky memErr.
module mem_stage #(
    parameter int DATA_W = 32
`ifdef MEM_TIMEOUT_EN
    , parameter int TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              haveInstrIn,
    input  logic [DATA_W-1:0] pcIn,
    input  logic              zeroIn,
    input  logic [DATA_W-1:0] ALUOutIn,
    input  logic [DATA_W-1:0] readData2In,
    input  logic [4:0]        regFromMuxIn,
    input  logic [1:0]        WBIn,
    input  logic              branchIn,
    input  logic              memReadIn,
    input  logic              memWriteIn,
    output logic              memReq,
    output logic              memWe,
    output logic [DATA_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memReady,
    output logic              stall,
    output logic              pcSrc,
    output logic [DATA_W-1:0] branchTarget,
    output logic [DATA_W-1:0] readDataOut,
    output logic [DATA_W-1:0] ALUOutOut,
    output logic [4:0]        regFromMuxOut,
    output logic [1:0]        WBOut,
    output logic              haveInstrOut,
    output logic              memErr
);
    typedef enum logic {IDLE, WAIT} state_e;

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [4:0]        reg_q, reg_d;
    logic [1:0]        wb_q, wb_d;
    logic              have_q, have_d;
    logic              stall_c;
    logic              timeout_hit;
    logic              acc;

    assign acc = haveInstrIn & (memReadIn | memWriteIn);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!memReady) begin
            if (timeout_hit) err_d = 1'b1;
            else             cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign memErr = err_q;
`else
    assign timeout_hit = 1'b0;
    assign memErr      = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        read_data_d = read_data_q;
        alu_out_d   = alu_out_q;
        reg_d       = reg_q;
        wb_d        = wb_q;
        have_d      = have_q;
        stall_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    stall_c     = 1'b1;
                    state_d     = WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = memWriteIn;
                    mem_addr_d  = ALUOutIn;
                    mem_wdata_d = readData2In;
                    have_d      = 1'b0;
                    wb_d        = 2'b00;
                end else begin
                    alu_out_d   = ALUOutIn;
                    reg_d       = regFromMuxIn;
                    wb_d        = haveInstrIn ? WBIn : 2'b00;
                    have_d      = haveInstrIn;
                    read_data_d = '0;
                end
            end
            WAIT: begin
                stall_c = ~(memReady | timeout_hit);
                if (memReady || timeout_hit) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    alu_out_d   = ALUOutIn;
                    reg_d       = regFromMuxIn;
                    wb_d        = WBIn;
                    have_d      = 1'b1;
                    read_data_d = mem_we_q ? '0 :
                                  memReady ? memRData : DATA_W'(32'hDEADBEEF);
                end else begin
                    have_d = 1'b0;
                    wb_d   = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            read_data_q <= '0;
            alu_out_q   <= '0;
            reg_q       <= '0;
            wb_q        <= '0;
            have_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            read_data_q <= read_data_d;
            alu_out_q   <= alu_out_d;
            reg_q       <= reg_d;
            wb_q        <= wb_d;
            have_q      <= have_d;
        end
    end

    // Reset releases the upstream freeze at once, even if a load is still presented.
    assign stall         = stall_c & ~reset;
    assign pcSrc         = haveInstrIn & branchIn & zeroIn & ~stall;
    assign branchTarget  = pcIn;
    assign memReq        = mem_req_q;
    assign memWe         = mem_we_q;
    assign memAddr       = mem_addr_q;
    assign memWData      = mem_wdata_q;
    assign readDataOut   = read_data_q;
    assign ALUOutOut     = alu_out_q;
    assign regFromMuxOut = reg_q;
    assign WBOut         = wb_q;
    assign haveInstrOut  = have_q;
endmodule
